// File: rtl/count_monitor_pkg.sv
// Shared types for count_monitor: event kinds, monitor FSM states and the queued event record.
package count_monitor_pkg;

    localparam int EVT_COUNT_W = 5;
    localparam int EVT_TS_W    = 8;

    typedef enum logic [1:0] {
        EVT_MATCH = 2'd0,
        EVT_WRAP  = 2'd1,
        EVT_SKIP  = 2'd2,
        EVT_STALL = 2'd3
    } evt_kind_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } mon_state_e;

    typedef struct packed {
        evt_kind_e              kind;
        logic [EVT_TS_W-1:0]    ts;
        logic [EVT_COUNT_W-1:0] count;
    } evt_t;

endpackage

// File: rtl/count_monitor_fifo.sv
// First-word-fall-through event FIFO; head is visible whenever empty is low.
module count_monitor_fifo
    import count_monitor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  evt_t din,
    input  logic pop,
    output evt_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    evt_t           mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/count_monitor.sv
// Watches a free-running count bus for wrap, threshold match and skips, queueing timestamped events.
// Optional stall detection is enabled by defining COUNT_MONITOR_STALL_DETECT_EN.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int COUNT_W = EVT_COUNT_W,
    parameter int DEPTH   = 4,
    parameter int TS_W    = EVT_TS_W,
    parameter int WRAP_W  = 8
`ifdef COUNT_MONITOR_STALL_DETECT_EN
   ,parameter int STALL_CYCLES = 16
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count,
    input  logic               arm,
    input  logic [COUNT_W-1:0] threshold,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [1:0]         evt_kind,
    output logic [TS_W-1:0]    evt_ts,
    output logic [COUNT_W-1:0] evt_count,
    output logic [WRAP_W-1:0]  wrap_cnt,
    output logic               hit,
    output logic               overflow
);

    mon_state_e         state;
    mon_state_e         state_next;
    logic [TS_W-1:0]    ts;
    logic [COUNT_W-1:0] prev;
    logic [COUNT_W-1:0] prev_inc;
    logic               primed;

    logic               match_det;
    logic               wrap_det;
    logic               skip_det;
    logic               stall_det;
    logic [3:0]         det;
    logic               multi;

    evt_t               new_evt;
    evt_t               head;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    assign prev_inc  = prev + 1'b1;
    assign wrap_det  = primed && (prev == '1) && (count == '0);
    assign skip_det  = primed && (count != prev) && (count != prev_inc);
    // Edge-qualified: a count parked on threshold does not re-fire.
    assign match_det = (state == ARMED) && primed && (count == threshold) && (prev != threshold);

`ifdef COUNT_MONITOR_STALL_DETECT_EN
    localparam int SW = $clog2(STALL_CYCLES + 1);
    logic [SW-1:0] stall_cnt;
    logic          same;

    assign same      = primed && (count == prev);
    assign stall_det = same && (stall_cnt == SW'(STALL_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                  stall_cnt <= '0;
        else if (!same)                              stall_cnt <= '0;
        else if (stall_cnt != SW'(STALL_CYCLES))     stall_cnt <= stall_cnt + 1'b1;
    end
`else
    assign stall_det = 1'b0;
`endif

    // Any second detector firing in the same cycle loses its slot.
    assign det   = {stall_det, skip_det, wrap_det, match_det};
    assign multi = |(det & (det - 4'd1));
    assign push  = |det;
    assign pop   = !empty && evt_ready;

    always_comb begin
        new_evt.ts    = ts;
        new_evt.count = count;
        if (match_det)     new_evt.kind = EVT_MATCH;
        else if (wrap_det) new_evt.kind = EVT_WRAP;
        else if (skip_det) new_evt.kind = EVT_SKIP;
        else               new_evt.kind = EVT_STALL;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts       <= '0;
            prev     <= '0;
            primed   <= 1'b0;
            wrap_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            ts     <= ts + 1'b1;
            prev   <= count;
            primed <= 1'b1;
            if (wrap_det && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + 1'b1;
            if (multi || (push && full && !pop)) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A match takes priority over arm dropping in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm) state_next = ARMED;
            ARMED:   if (match_det) state_next = HIT;
                     else if (!arm) state_next = IDLE;
            HIT:     if (!arm) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hit = (state == HIT);
    end

    count_monitor_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (new_evt),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign evt_valid = !empty;
    assign evt_kind  = empty ? 2'b00 : head.kind;
    assign evt_ts    = empty ? '0 : head.ts;
    assign evt_count = empty ? '0 : head.count;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: wrap, match, skip, priority drop, FIFO fill/drain, async reset.
module tb_count_monitor;
    import count_monitor_pkg::*;

    logic       clock;
    logic       reset;
    logic [4:0] count;
    logic       arm;
    logic [4:0] threshold;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_kind;
    logic [7:0] evt_ts;
    logic [4:0] evt_count;
    logic [7:0] wrap_cnt;
    logic       hit;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    count_monitor dut (
        .clock     (clock),
        .reset     (reset),
        .count     (count),
        .arm       (arm),
        .threshold (threshold),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_kind  (evt_kind),
        .evt_ts    (evt_ts),
        .evt_count (evt_count),
        .wrap_cnt  (wrap_cnt),
        .hit       (hit),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present c, let one rising edge sample it, return 2 time units later.
    task automatic drive(input logic [4:0] c);
        count = c;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        count     = 5'd0;
        arm       = 1'b0;
        threshold = 5'd0;
        evt_ready = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; count = 5'd0; arm = 1'b0; threshold = 5'd0; evt_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_wrap",  wrap_cnt,  0);
        check("rst_hit",   hit,       0);
        check("rst_ovf",   overflow,  0);
        check("rst_kind",  evt_kind,  0);

        // 1: clean ramp then wrap at drive index 32
        for (int i = 0; i < 32; i++) drive(5'(i));
        check("t1_noevt", evt_valid, 0);
        drive(5'd0);
        check("t1_valid", evt_valid, 1);
        check("t1_kind",  evt_kind,  EVT_WRAP);
        check("t1_ts",    evt_ts,    32);
        check("t1_count", evt_count, 0);
        check("t1_wrap",  wrap_cnt,  1);
        check("t1_ovf",   overflow,  0);
        evt_ready = 1'b1;
        drive(5'd1);
        check("t1_drained", evt_valid, 0);

        // 2: threshold match, HIT holds until arm toggles
        do_reset();
        arm = 1'b1; threshold = 5'd7;
        for (int i = 0; i < 8; i++) drive(5'(i));
        check("t2_valid", evt_valid, 1);
        check("t2_kind",  evt_kind,  EVT_MATCH);
        check("t2_count", evt_count, 7);
        check("t2_ts",    evt_ts,    7);
        check("t2_hit",   hit,       1);
        evt_ready = 1'b1;
        for (int i = 8; i < 32; i++) drive(5'(i));
        for (int i = 0; i < 8; i++) drive(5'(i));
        check("t2_nomatch", evt_valid, 0);
        check("t2_hit_hold", hit, 1);
        arm = 1'b0;
        drive(5'd8);
        check("t2_hit_clr", hit, 0);
        arm = 1'b1;
        for (int i = 9; i < 32; i++) drive(5'(i));
        drive(5'd0);
        evt_ready = 1'b0;
        for (int i = 1; i < 8; i++) drive(5'(i));
        check("t2_rematch_valid", evt_valid, 1);
        check("t2_rematch_kind",  evt_kind,  EVT_WRAP);
        check("t2_rematch_ts",    evt_ts,    64);
        evt_ready = 1'b1;
        drive(5'd8);
        check("t2_rematch_kind2", evt_kind,  EVT_MATCH);
        check("t2_rematch_ts2",   evt_ts,    71);
        check("t2_wrap2",         wrap_cnt,  2);

        // 3: skips
        do_reset();
        drive(5'd3); drive(5'd4); drive(5'd5); drive(5'd9);
        check("t3_kind",  evt_kind,  EVT_SKIP);
        check("t3_count", evt_count, 9);
        check("t3_ts",    evt_ts,    3);
        evt_ready = 1'b1;
        for (int i = 10; i < 21; i++) drive(5'(i));
        check("t3_drained", evt_valid, 0);
        drive(5'd0);
        check("t3_rst_kind",  evt_kind,  EVT_SKIP);
        check("t3_rst_count", evt_count, 0);
        check("t3_rst_ts",    evt_ts,    15);
        check("t3_wrap",      wrap_cnt,  0);

        // 4: MATCH and WRAP coincide, WRAP dropped
        do_reset();
        arm = 1'b1; threshold = 5'd0;
        drive(5'd28); drive(5'd29); drive(5'd30); drive(5'd31); drive(5'd0);
        check("t4_kind",  evt_kind,  EVT_MATCH);
        check("t4_count", evt_count, 0);
        check("t4_ts",    evt_ts,    4);
        check("t4_ovf",   overflow,  1);
        check("t4_wrap",  wrap_cnt,  1);
        check("t4_hit",   hit,       1);
        evt_ready = 1'b1;
        drive(5'd1);
        check("t4_single", evt_valid, 0);

        // 5: five wraps into a 4-deep FIFO, then drain in order
        do_reset();
        drive(5'd0);
        for (int w = 0; w < 5; w++) begin
            for (int i = 1; i < 32; i++) drive(5'(i));
            drive(5'd0);
            if (w == 3) check("t5_full_noovf", overflow, 0);
        end
        check("t5_ovf",  overflow, 1);
        check("t5_wrap", wrap_cnt, 5);
        evt_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            check("t5_valid", evt_valid, 1);
            check("t5_kind",  evt_kind,  EVT_WRAP);
            check("t5_ts",    evt_ts,    32'((d + 1) * 32));
            drive(5'(d + 1));
        end
        check("t5_empty", evt_valid, 0);

        // 6: async reset with 3 queued
        do_reset();
        arm = 1'b1; threshold = 5'd10;
        drive(5'd30); drive(5'd31); drive(5'd0); drive(5'd5); drive(5'd10);
        check("t6_pre_valid", evt_valid, 1);
        check("t6_pre_hit",   hit,       1);
        check("t6_pre_wrap",  wrap_cnt,  1);
        check("t6_pre_ovf",   overflow,  1);
        reset = 1'b0;
        #1;
        check("t6_valid", evt_valid, 0);
        check("t6_wrap",  wrap_cnt,  0);
        check("t6_hit",   hit,       0);
        check("t6_ovf",   overflow,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
